// File: rtl/riscv_defines.sv
// Shared definitions for the string-op execution datapath: operator encodings,
// FSM state enum and the ASCII constants used by the per-byte transforms.
// Pure declarations, no logic; imported by every file of the string-op unit.
package riscv_defines;

    localparam int STR_OP_WIDTH = 3;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

    typedef enum logic [1:0] {
        STR_IDLE = 2'd0,
        STR_BUSY = 2'd1,
        STR_DONE = 2'd2
    } str_fsm_e;

    localparam logic [7:0] CHR_a   = 8'h61;
    localparam logic [7:0] CHR_z   = 8'h7A;
    localparam logic [7:0] CHR_A   = 8'h41;
    localparam logic [7:0] CHR_Z   = 8'h5A;
    localparam logic [7:0] CHR_NUL = 8'h00;
    localparam logic [7:0] ROT_AMT = 8'd13;

    // Distance between upper and lower case, and the alphabet length used for
    // the ROT13 wrap.
    localparam logic [7:0] CASE_DELTA = 8'h20;
    localparam logic [7:0] ALPHA_LEN  = 8'd26;

    // Lower-case letters that LEET rewrites and the digits they become.
    localparam logic [7:0] CHR_e = 8'h65;
    localparam logic [7:0] CHR_i = 8'h69;
    localparam logic [7:0] CHR_o = 8'h6F;
    localparam logic [7:0] CHR_s = 8'h73;
    localparam logic [7:0] CHR_t = 8'h74;
    localparam logic [7:0] CHR_0 = 8'h30;
    localparam logic [7:0] CHR_1 = 8'h31;
    localparam logic [7:0] CHR_3 = 8'h33;
    localparam logic [7:0] CHR_4 = 8'h34;
    localparam logic [7:0] CHR_5 = 8'h35;
    localparam logic [7:0] CHR_7 = 8'h37;

endpackage

// File: rtl/riscv_str_byte_xform.sv
// Per-byte ASCII transform for UPPER / LOWER / LEET / ROT13; unknown ops pass through.
// Latency: purely combinational.
// Backpressure: none; the owning sequencer decides when the output is used.
// Ports: operator_i (op select), byte_i (input char), byte_o (transformed char),
//        is_nul_o (byte_i is 0x00).
module riscv_str_byte_xform
    import riscv_defines::*;
(
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [7:0]              byte_i,
    output logic [7:0]              byte_o,
    output logic                    is_nul_o
);

    logic       is_lower;
    logic       is_upper;
    logic [7:0] folded;
    logic [7:0] rot_sum;

    assign is_nul_o = (byte_i == CHR_NUL);
    assign is_lower = (byte_i >= CHR_a) && (byte_i <= CHR_z);
    assign is_upper = (byte_i >= CHR_A) && (byte_i <= CHR_Z);
    // LEET is case-insensitive: fold letters to lower case before matching.
    assign folded   = is_upper ? (byte_i + CASE_DELTA) : byte_i;
    // Inputs are at most 0x7A, so the 8-bit sum never overflows.
    assign rot_sum  = byte_i + ROT_AMT;

    always_comb begin
        byte_o = byte_i;
        case (operator_i)
            STR_OP_UPPER: begin
                if (is_lower) byte_o = byte_i - CASE_DELTA;
            end
            STR_OP_LOWER: begin
                if (is_upper) byte_o = byte_i + CASE_DELTA;
            end
            STR_OP_LEET: begin
                if (is_lower || is_upper) begin
                    case (folded)
                        CHR_a:   byte_o = CHR_4;
                        CHR_e:   byte_o = CHR_3;
                        CHR_i:   byte_o = CHR_1;
                        CHR_o:   byte_o = CHR_0;
                        CHR_s:   byte_o = CHR_5;
                        CHR_t:   byte_o = CHR_7;
                        default: byte_o = byte_i;
                    endcase
                end
            end
            STR_OP_ROT13: begin
                if (is_lower) begin
                    byte_o = (rot_sum > CHR_z) ? (rot_sum - ALPHA_LEN) : rot_sum;
                end else if (is_upper) begin
                    byte_o = (rot_sum > CHR_Z) ? (rot_sum - ALPHA_LEN) : rot_sum;
                end
            end
            default: byte_o = byte_i;
        endcase
    end

endmodule

// File: rtl/riscv_str_ops_seq.sv
// Multi-cycle string-op datapath: transforms 4 packed chars BYTES_PER_CYCLE at a time, stops at NUL.
// Latency: accept in C -> valid_o in C + 4/BYTES_PER_CYCLE + 1 (earlier on NUL).
// Backpressure: result held in DONE until ex_ready_i; ready_o low while busy or result pending.
// Ports: clk, rst_n; enable_i/operator_i/operand_i (request, taken when ready_o=1);
//        ex_ready_i/valid_o/result_o/zero_found_o/zero_idx_o (result handshake).
module riscv_str_ops_seq
    import riscv_defines::*;
#(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic [STR_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    input  logic                    ex_ready_i,
    output logic                    ready_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    output logic                    zero_found_o,
    output logic [1:0]              zero_idx_o
);

    str_fsm_e                state_q, state_d;
    logic [STR_OP_WIDTH-1:0] op_q;
    logic [31:0]             data_q, data_nxt;
    logic [2:0]              cnt_q, cnt_nxt;
    logic                    zf_q, zf_nxt;
    logic [1:0]              zi_q, zi_nxt;
    logic                    accept;
    logic                    busy_last;

    logic [BYTES_PER_CYCLE-1:0][1:0] byte_idx;
    logic [BYTES_PER_CYCLE-1:0][7:0] byte_in;
    logic [BYTES_PER_CYCLE-1:0][7:0] byte_out;
    logic [BYTES_PER_CYCLE-1:0]      byte_nul;

    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
        assign byte_idx[g] = cnt_q[1:0] + 2'(g);
        assign byte_in[g]  = data_q[{byte_idx[g], 3'b000} +: 8];

        riscv_str_byte_xform u_xform (
            .operator_i (op_q),
            .byte_i     (byte_in[g]),
            .byte_o     (byte_out[g]),
            .is_nul_o   (byte_nul[g])
        );
    end

    // Lanes are scanned in byte order so a NUL freezes itself and every later
    // lane of the same group.
    always_comb begin
        data_nxt = data_q;
        zf_nxt   = zf_q;
        zi_nxt   = zi_q;
        for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
            if (!zf_nxt) begin
                if (byte_nul[g]) begin
                    zf_nxt = 1'b1;
                    zi_nxt = byte_idx[g];
                end else begin
                    data_nxt[{byte_idx[g], 3'b000} +: 8] = byte_out[g];
                end
            end
        end
    end

    // zf_q is cleared on accept, so zf_nxt in BUSY means a NUL in this group.
    assign cnt_nxt   = cnt_q + 3'(BYTES_PER_CYCLE);
    assign busy_last = cnt_nxt[2] || zf_nxt;
    assign accept    = ready_o && enable_i;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= STR_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            STR_IDLE: if (enable_i) state_d = STR_BUSY;
            STR_BUSY: if (busy_last) state_d = STR_DONE;
            STR_DONE: if (ex_ready_i) state_d = enable_i ? STR_BUSY : STR_IDLE;
            default:  state_d = STR_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (state_q)
            STR_IDLE: ready_o = 1'b1;
            STR_DONE: begin
                ready_o = ex_ready_i;
                valid_o = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
                valid_o = 1'b0;
            end
        endcase
    end

    // Working word: loaded on accept, rewritten in place while BUSY, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            zf_q   <= 1'b0;
            zi_q   <= '0;
        end else if (accept) begin
            op_q   <= operator_i;
            data_q <= operand_i;
            cnt_q  <= '0;
            zf_q   <= 1'b0;
            zi_q   <= '0;
        end else if (state_q == STR_BUSY) begin
            data_q <= data_nxt;
            cnt_q  <= cnt_nxt;
            zf_q   <= zf_nxt;
            zi_q   <= zi_nxt;
        end
    end

    assign result_o     = data_q;
    assign zero_found_o = zf_q;
    assign zero_idx_o   = zi_q;

endmodule

// File: tb/tb_riscv_str_ops_seq.sv
// Scoreboard bench for riscv_str_ops_seq with one BYTES_PER_CYCLE=1 and one
// BYTES_PER_CYCLE=4 instance; sel picks which instance is driven and observed.
module tb_riscv_str_ops_seq;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        enable = 1'b0;
    logic        ex_ready = 1'b1;
    logic [2:0]  op = '0;
    logic [31:0] operand = '0;

    logic        rdy1, vld1, zf1, rdy4, vld4, zf4;
    logic [31:0] res1, res4;
    logic [1:0]  zi1, zi4;

    logic        m_ready, m_valid, m_zf;
    logic [31:0] m_result;
    logic [1:0]  m_zi;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_str_ops_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable && !sel), .operator_i(op),
        .operand_i(operand), .ex_ready_i(ex_ready), .ready_o(rdy1), .valid_o(vld1),
        .result_o(res1), .zero_found_o(zf1), .zero_idx_o(zi1)
    );

    riscv_str_ops_seq #(.BYTES_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable_i(enable && sel), .operator_i(op),
        .operand_i(operand), .ex_ready_i(ex_ready), .ready_o(rdy4), .valid_o(vld4),
        .result_o(res4), .zero_found_o(zf4), .zero_idx_o(zi4)
    );

    assign m_ready  = sel ? rdy4 : rdy1;
    assign m_valid  = sel ? vld4 : vld1;
    assign m_result = sel ? res4 : res1;
    assign m_zf     = sel ? zf4  : zf1;
    assign m_zi     = sel ? zi4  : zi1;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic [1:0]  zi;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [2:0] o, input logic [7:0] b);
        int v;
        v = int'(b);
        case (o)
            3'd0: if (v >= 97 && v <= 122) v = v - 32;
            3'd1: if (v >= 65 && v <= 90) v = v + 32;
            3'd2: case (b)
                      "a", "A": v = 52;
                      "e", "E": v = 51;
                      "i", "I": v = 49;
                      "o", "O": v = 48;
                      "s", "S": v = 53;
                      "t", "T": v = 55;
                      default: v = int'(b);
                  endcase
            3'd3: begin
                if (v >= 97 && v <= 122)     v = 97 + (v - 97 + 13) % 26;
                else if (v >= 65 && v <= 90) v = 65 + (v - 65 + 13) % 26;
            end
            default: v = int'(b);
        endcase
        return v[7:0];
    endfunction

    function automatic exp_t ref_op(input logic [2:0] o, input logic [31:0] w, input int bpc);
        exp_t e;
        int   k;
        logic [7:0] b;
        e.res = w;
        e.zf  = 1'b0;
        e.zi  = 2'd0;
        k = 4;
        for (int i = 0; i < 4; i++) begin
            b = w[i*8 +: 8];
            if (k == 4) begin
                if (b == 8'h00) k = i;
                else e.res[i*8 +: 8] = ref_byte(o, b);
            end
        end
        if (k < 4) begin
            e.zf  = 1'b1;
            e.zi  = 2'(k);
            e.lat = k / bpc + 2;
        end else begin
            e.lat = 4 / bpc + 1;
        end
        e.acc = 0;
        return e;
    endfunction

    // Called just after a posedge. Holds enable until the op is taken.
    task automatic issue(input logic s, input logic [2:0] o, input logic [31:0] w);
        exp_t e;
        int   n;
        sel = s; op = o; operand = w; enable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!m_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            e = ref_op(o, w, s ? 4 : 1);
            e.acc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic prev_valid = 1'b0;
    int   first_cyc = 0;

    task automatic monitor();
        exp_t e;
        int   fc;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                fc = (m_valid && !prev_valid) ? cyc : first_cyc;
                first_cyc = fc;
                if (m_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        chk("ready_follows_ex_ready", {31'd0, m_ready}, {31'd0, ex_ready});
                        if (!ex_ready) begin
                            chk("hold_result", m_result, sb[0].res);
                            chk("hold_zero_found", {31'd0, m_zf}, {31'd0, sb[0].zf});
                        end else begin
                            e = sb.pop_front();
                            chk("result", m_result, e.res);
                            chk("zero_found", {31'd0, m_zf}, {31'd0, e.zf});
                            if (e.zf) chk("zero_idx", {30'd0, m_zi}, {30'd0, e.zi});
                            chk("latency", fc - e.acc, e.lat);
                        end
                    end
                end
                prev_valid = m_valid;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},  {31'd0, m_ready},  32'd1);
        chk({tag, "_valid"},  {31'd0, m_valid},  32'd0);
        chk({tag, "_result"}, m_result,          32'd0);
        chk({tag, "_zf"},     {31'd0, m_zf},     32'd0);
        chk({tag, "_zi"},     {30'd0, m_zi},     32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #12;
        sel = 1'b0; #1 check_reset_state("rst1");
        sel = 1'b1; #1 check_reset_state("rst4");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // BYTES_PER_CYCLE=1 directed vectors
        issue(1'b0, STR_OP_UPPER, 32'h64636261); wait_drain();
        issue(1'b0, STR_OP_ROT13, 32'h7A6E4D41); wait_drain();
        issue(1'b0, STR_OP_LEET,  32'h78657461); wait_drain();
        issue(1'b0, STR_OP_LEET,  32'h45494F53); wait_drain();
        issue(1'b0, STR_OP_LOWER, 32'h41420043); wait_drain();
        issue(1'b0, STR_OP_UPPER, 32'h61626300); wait_drain();
        issue(1'b0, 3'd5,         32'h61415A7A); wait_drain();

        // BYTES_PER_CYCLE=4 directed vectors
        issue(1'b1, STR_OP_LOWER, 32'h41420043); wait_drain();
        issue(1'b1, STR_OP_ROT13, 32'h7A6E4D41); wait_drain();
        issue(1'b1, STR_OP_UPPER, 32'h00636261); wait_drain();

        // Random letters/digits with an occasional NUL on both widths
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            for (int j = 0; j < 4; j++) begin
                w[j*8 +: 8] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(8'h30, 8'h7A));
            end
            issue(i[0], 3'($urandom_range(0, 4)), w);
            wait_drain();
        end

        // Backpressure, then back-to-back accept in the handshake cycle
        sel = 1'b0;
        ex_ready = 1'b0;
        issue(1'b0, STR_OP_UPPER, 32'h74736574);
        begin
            int n;
            n = 0;
            while (!m_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_seen", {31'd0, m_valid}, 32'd1);
        end
        repeat (3) @(negedge clk);
        chk("bp_ready_low", {31'd0, m_ready}, 32'd0);
        @(posedge clk);
        #1 ex_ready = 1'b1;
        issue(1'b0, STR_OP_ROT13, 32'h6E6D7A61);
        @(negedge clk);
        chk("b2b_valid_drop", {31'd0, m_valid}, 32'd0);
        wait_drain();

        // Asynchronous reset in the middle of BUSY
        issue(1'b0, STR_OP_UPPER, 32'h64636261);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_state("rst_busy");
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, STR_OP_LOWER, 32'h5A594241); wait_drain();
        issue(1'b1, STR_OP_LEET,  32'h6F746573); wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/riscv_str_ops_seq.md
Name: riscv_str_ops_seq

Overview:
- Multi-cycle execution datapath for the custom string-op instructions UPPER, LOWER, LEET and ROT13.
- Sits in EX, fed by the same decode signals as the string-op monitor (enable, operator) plus the rs1 operand word.
- Transforms the 4 packed ASCII bytes of the operand BYTES_PER_CYCLE bytes at a time.
- Returns the result to EX/WB via a valid/ready handshake, with an early exit on NUL.

Parameters:
BYTES_PER_CYCLE, 1, bytes transformed per BUSY cycle; legal values 1, 2, 4.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
enable_i  input  1  decoded string-op request; sampled only when ready_o=1
operator_i  input  STR_OP_WIDTH  STR_OP_UPPER / STR_OP_LOWER / STR_OP_LEET / STR_OP_ROT13
operand_i  input  32  packed chars; byte 0 = bits 7:0 = first char
ex_ready_i  input  1  downstream accepts result this cycle
ready_o  output  1  unit can accept a new op this cycle (EX stalls while 0)
valid_o  output  1  result_o/zero_* valid
result_o  output  32  transformed word
zero_found_o  output  1  a 0x00 byte was seen
zero_idx_o  output  2  index of the first 0x00 byte

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result_o=0, valid_o=0, zero_found_o=0, zero_idx_o=0, byte counter=0. ready_o=1 follows from IDLE. Reset mid-operation discards the op.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1.
  - enable_i=1: latch operand, operator; clear zero flags; counter=0; go to BUSY.
- BUSY:
  - ready_o=0; enable_i ignored.
  - Each edge transforms bytes [counter .. counter+BYTES_PER_CYCLE-1] in place, then advances counter by BYTES_PER_CYCLE.
  - Go to DONE after byte 3 is processed, or in the cycle a 0x00 byte is processed.
- DONE:
  - valid_o=1; result_o, zero_found_o and zero_idx_o are held stable until the handshake.
  - ready_o = ex_ready_i.
  - ex_ready_i=1: go to IDLE, or straight to BUSY if enable_i=1 in the same cycle (back-to-back). valid_o drops the next cycle.
- Latency: enable_i sampled in cycle C gives valid_o in cycle C + 4/BYTES_PER_CYCLE + 1 without a NUL. With a NUL, DONE follows the BUSY cycle that processed it.
- NUL rule:
  - The first 0x00 byte sets zero_found_o=1 and zero_idx_o=its index.
  - That byte and all later bytes (including later bytes in the same group) pass through unchanged.
- Per-byte transforms (all other bytes unchanged):
  - UPPER: 0x61-0x7A minus 0x20.
  - LOWER: 0x41-0x5A plus 0x20.
  - LEET, either case: a->'4' (0x34), e->'3', i->'1', o->'0', s->'5', t->'7'.
  - ROT13: letter + 13 within its case, wrapping past 'z'/'Z' (e.g. 'n'->'a', 'Z'->'M').
  - Unknown operator: pass-through; op still completes normally.
- Arithmetic: all transforms are 8-bit with no carry into adjacent bytes. ROT13 compare/subtract is done on the 8-bit value, with the wrap computed as c+13-26 when c+13 exceeds the case's last letter.

Decomposition:
- Add to riscv_defines:
  - STR_OP_WIDTH and the STR_OP_* encodings (already there);
  - str_fsm_e state enum (STR_IDLE, STR_BUSY, STR_DONE);
  - character constants CHR_a, CHR_z, CHR_A, CHR_Z, CHR_NUL, ROT_AMT=13.
- Sub-module riscv_str_byte_xform: purely combinational. Inputs: operator and one byte. Outputs: transformed byte and is_nul. Instantiated BYTES_PER_CYCLE times.

Test Plan:
1. BYTES_PER_CYCLE=1, UPPER, operand 0x64636261, enable at C -> valid_o at C+5, result_o=0x44434241, zero_found_o=0.
2. ROT13, operand 0x7A6E4D41 ("AMnz") -> result_o=0x6D615A4E (wraps checked).
3. LEET, operand 0x78657461 -> result_o=0x78333734 ('x' unchanged).
4. LOWER, operand 0x41420043, BYTES_PER_CYCLE=1 -> valid_o at C+3, result_o=0x41420063, zero_found_o=1, zero_idx_o=1. Repeat with BYTES_PER_CYCLE=4 -> valid_o at C+2, same result.
5. Backpressure: in DONE hold ex_ready_i=0 for 3 cycles -> valid_o/result_o stable, ready_o=0. Then ex_ready_i=1 with enable_i=1 and a new operand -> new op accepted that cycle, valid_o=0 next cycle, then the new result.
6. Reset: assert rst_n=0 during BUSY -> valid_o=0, result_o=0, zero_found_o=0 asynchronously, ready_o=1. After release, the next enable_i completes a fresh op with correct latency.
